// File: rtl/hazard_pkg.sv
// Shared types and constants for the ID-stage hazard/forwarding controller.
// Scoreboard destinations are held at SB_DST_W bits, enough for any REG_AW up to 8.
package hazard_pkg;
   localparam int SB_DST_W = 8;

   typedef struct packed {
      logic                v;
      logic [SB_DST_W-1:0] dst;
      logic                ld;
   } sb_entry_t;

   localparam int FWD_RF = 0;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_J     = 6'b000010;
endpackage

// File: rtl/hazard_sb.sv
// In-flight register-write scoreboard: sb[0] is EX, sb[DEPTH-1] is WB.
// A flush bubbles both the slot being filled from ID and the slot the EX entry would move into.
module hazard_sb
   import hazard_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int DEPTH  = 3
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    push,
   input  logic                    flush,
   input  logic [REG_AW-1:0]       push_dst,
   input  logic                    push_ld,
   output sb_entry_t [DEPTH-1:0]   sb
);

   sb_entry_t head;

   always_comb begin
      head = '0;
      if (push) begin
         head.v   = 1'b1;
         head.dst = SB_DST_W'(push_dst);
         head.ld  = push_ld;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sb <= '0;
      end else begin
         sb[0] <= head;
         for (int k = 1; k < DEPTH; k++) sb[k] <= sb[k-1];
         if (flush) sb[1] <= '0;
      end
   end

endmodule

// File: rtl/hazard_unit_p.sv
// Hazard and forwarding controller beside ID: same-cycle stall, registered EX forward selects,
// and a saturating stall counter, all driven from a private scoreboard of pending writes.
module hazard_unit_p
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int DEPTH    = 3,
   parameter int FWD_EN   = 1,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 16,
   localparam int FW      = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_wr_en,
   input  logic [REG_AW-1:0] id_wr_dst,
   input  logic              id_is_load,
   input  logic              ex_flush,
   output logic              stall,
   output logic [FW-1:0]     ex_fwd_rs,
   output logic [FW-1:0]     ex_fwd_rt,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic              sb_busy
);

   sb_entry_t [DEPTH-1:0] sb;
   logic                  push;
   logic                  haz;
   logic                  m_rs, m_rt, lu_rs, lu_rt;
   logic [FW-1:0]         y_rs, y_rt;

   // Scan oldest to youngest so the youngest matching producer is the one left standing.
   always_comb begin
      m_rs  = 1'b0;
      m_rt  = 1'b0;
      lu_rs = 1'b0;
      lu_rt = 1'b0;
      y_rs  = '0;
      y_rt  = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (id_use_rs && id_rs != '0 && sb[k].v && sb[k].dst == SB_DST_W'(id_rs)) begin
            m_rs  = 1'b1;
            y_rs  = FW'(k);
            lu_rs = sb[k].ld && (k < LOAD_LAT);
         end
         if (id_use_rt && id_rt != '0 && sb[k].v && sb[k].dst == SB_DST_W'(id_rt)) begin
            m_rt  = 1'b1;
            y_rt  = FW'(k);
            lu_rt = sb[k].ld && (k < LOAD_LAT);
         end
      end
   end

   always_comb begin
      if (FWD_EN == 0) haz = id_valid && (m_rs || m_rt);
      else             haz = id_valid && (lu_rs || lu_rt);
   end

   assign stall = haz && !ex_flush;
   assign push  = id_valid && id_wr_en && id_wr_dst != '0 && !stall && !ex_flush;

   hazard_sb #(
      .REG_AW (REG_AW),
      .DEPTH  (DEPTH)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .flush    (ex_flush),
      .push_dst (id_wr_dst),
      .push_ld  (id_is_load),
      .sb       (sb)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         ex_fwd_rs <= FW'(FWD_RF);
         ex_fwd_rt <= FW'(FWD_RF);
         stall_cnt <= '0;
      end else begin
         if (FWD_EN != 0 && id_valid && !stall && !ex_flush) begin
            ex_fwd_rs <= m_rs ? y_rs + FW'(1) : FW'(FWD_RF);
            ex_fwd_rt <= m_rt ? y_rt + FW'(1) : FW'(FWD_RF);
         end else begin
            ex_fwd_rs <= FW'(FWD_RF);
            ex_fwd_rt <= FW'(FWD_RF);
         end
         if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      end
   end

   always_comb begin
      sb_busy = 1'b0;
      for (int k = 0; k < DEPTH; k++) sb_busy = sb_busy | sb[k].v;
   end

endmodule

// File: tb/tb_hazard_unit_p.sv
// Drives three hazard_unit_p configurations from one instruction stream and checks each
// against an age-tracking model of pending writes, plus hand-worked pipeline scenarios.
module tb_hazard_unit_p;
   import hazard_pkg::*;

   localparam int DEPTH    = 3;
   localparam int LOAD_LAT = 1;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, ex_flush;
   logic [4:0] id_rs, id_rt, id_wr_dst;

   logic        st0, st1, st2, bz0, bz1, bz2;
   logic [1:0]  frs0, frt0, frs1, frt1, frs2, frt2;
   logic [15:0] cnt0, cnt1;
   logic [3:0]  cnt2;

   always #5 clk = ~clk;

   hazard_unit_p #(.FWD_EN(0)) u0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wr_dst(id_wr_dst),
      .id_is_load(id_is_load), .ex_flush(ex_flush), .stall(st0), .ex_fwd_rs(frs0),
      .ex_fwd_rt(frt0), .stall_cnt(cnt0), .sb_busy(bz0));

   hazard_unit_p #(.FWD_EN(1)) u1 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wr_dst(id_wr_dst),
      .id_is_load(id_is_load), .ex_flush(ex_flush), .stall(st1), .ex_fwd_rs(frs1),
      .ex_fwd_rt(frt1), .stall_cnt(cnt1), .sb_busy(bz1));

   hazard_unit_p #(.FWD_EN(0), .CNT_W(4)) u2 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_wr_dst(id_wr_dst),
      .id_is_load(id_is_load), .ex_flush(ex_flush), .stall(st2), .ex_fwd_rs(frs2),
      .ex_fwd_rt(frt2), .stall_cnt(cnt2), .sb_busy(bz2));

   int n_tot  = 0;
   int n_pass = 0;
   bit chk_on = 0;

   task automatic chk(input string nm, input int act, input int exp);
      n_tot++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   // Model: a pool of pending writes per configuration, each tagged with its age since issue.
   bit         m_live[3][8];
   logic [4:0] m_dst[3][8];
   bit         m_ld[3][8];
   int         m_age[3][8];
   int         e_frs[3], e_frt[3], e_cnt[3];

   int act_st[3], act_frs[3], act_frt[3], act_cnt[3], act_bz[3];
   always_comb begin
      act_st[0]  = int'(st0);  act_st[1]  = int'(st1);  act_st[2]  = int'(st2);
      act_frs[0] = int'(frs0); act_frs[1] = int'(frs1); act_frs[2] = int'(frs2);
      act_frt[0] = int'(frt0); act_frt[1] = int'(frt1); act_frt[2] = int'(frt2);
      act_cnt[0] = int'(cnt0); act_cnt[1] = int'(cnt1); act_cnt[2] = int'(cnt2);
      act_bz[0]  = int'(bz0);  act_bz[1]  = int'(bz1);  act_bz[2]  = int'(bz2);
   end

   always @(negedge clk) begin
      if (chk_on) begin
         for (int c = 0; c < 3; c++) begin
            int  brs, brt, cmax, nrs, nrt;
            bit  fe, haz, e_st, busy, placed;
            fe   = (c == 1);
            cmax = (c == 2) ? 15 : 65535;
            brs  = -1;
            brt  = -1;
            busy = 0;
            for (int i = 0; i < 8; i++) begin
               if (m_live[c][i]) begin
                  busy = 1;
                  if (id_use_rs && id_rs != 0 && m_dst[c][i] == id_rs &&
                      (brs < 0 || m_age[c][i] < m_age[c][brs])) brs = i;
                  if (id_use_rt && id_rt != 0 && m_dst[c][i] == id_rt &&
                      (brt < 0 || m_age[c][i] < m_age[c][brt])) brt = i;
               end
            end
            if (!fe) haz = id_valid && (brs >= 0 || brt >= 0);
            else haz = id_valid &&
                       ((brs >= 0 && m_ld[c][brs] && m_age[c][brs] < LOAD_LAT) ||
                        (brt >= 0 && m_ld[c][brt] && m_age[c][brt] < LOAD_LAT));
            e_st = haz && !ex_flush;

            chk($sformatf("u%0d_stall", c),  act_st[c],  int'(e_st));
            chk($sformatf("u%0d_fwd_rs", c), act_frs[c], e_frs[c]);
            chk($sformatf("u%0d_fwd_rt", c), act_frt[c], e_frt[c]);
            chk($sformatf("u%0d_cnt", c),    act_cnt[c], e_cnt[c]);
            chk($sformatf("u%0d_busy", c),   act_bz[c],  int'(busy));

            if (rst) begin
               for (int i = 0; i < 8; i++) m_live[c][i] = 0;
               e_frs[c] = 0;
               e_frt[c] = 0;
               e_cnt[c] = 0;
            end else begin
               nrs = 0;
               nrt = 0;
               if (!e_st && !ex_flush && id_valid && fe) begin
                  if (brs >= 0) nrs = m_age[c][brs] + 1;
                  if (brt >= 0) nrt = m_age[c][brt] + 1;
               end
               e_frs[c] = nrs;
               e_frt[c] = nrt;
               if (e_st && e_cnt[c] < cmax) e_cnt[c]++;
               for (int i = 0; i < 8; i++) begin
                  if (m_live[c][i]) begin
                     m_age[c][i]++;
                     if (m_age[c][i] >= DEPTH) m_live[c][i] = 0;
                     else if (ex_flush && m_age[c][i] == 1) m_live[c][i] = 0;
                  end
               end
               if (id_valid && id_wr_en && id_wr_dst != 0 && !e_st && !ex_flush) begin
                  placed = 0;
                  for (int i = 0; i < 8; i++) begin
                     if (!placed && !m_live[c][i]) begin
                        m_live[c][i] = 1;
                        m_dst[c][i]  = id_wr_dst;
                        m_ld[c][i]   = id_is_load;
                        m_age[c][i]  = 0;
                        placed = 1;
                     end
                  end
               end
            end
         end
      end
   end

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic idle();
      id_valid = 0; id_rs = '0; id_rt = '0; id_use_rs = 0; id_use_rt = 0;
      id_wr_en = 0; id_wr_dst = '0; id_is_load = 0; ex_flush = 0;
   endtask

   task automatic drain();
      next();
      idle();
      repeat (3) next();
   endtask

   task automatic set_instr(input logic [5:0] op, input int rs, input int rt, input int rd);
      id_valid = 1; id_rs = 5'(rs); id_rt = 5'(rt);
      id_use_rs = 0; id_use_rt = 0; id_wr_en = 0; id_wr_dst = '0; id_is_load = 0;
      case (op)
         OP_RTYPE: begin id_use_rs = 1; id_use_rt = 1; id_wr_en = 1; id_wr_dst = 5'(rd); end
         OP_ADDI:  begin id_use_rs = 1; id_wr_en = 1; id_wr_dst = 5'(rt); end
         OP_LW:    begin id_use_rs = 1; id_wr_en = 1; id_wr_dst = 5'(rt); id_is_load = 1; end
         default:  ;
      endcase
   endtask

   initial begin
      rst = 1;
      idle();
      next();
      chk_on = 1;
      next();
      rst = 0;
      at_neg();
      chk("rst_cnt0", int'(cnt0), 0);
      chk("rst_busy0", int'(bz0), 0);
      chk("rst_fwd1", int'(frs1), 0);

      // Back-to-back RAW without forwarding: three stall cycles.
      next(); set_instr(OP_ADDI, 0, 8, 0);
      next(); set_instr(OP_RTYPE, 8, 0, 9);
      at_neg(); chk("t1_stall_c1", int'(st0), 1);
      next(); at_neg(); chk("t1_stall_c2", int'(st0), 1);
      next(); at_neg(); chk("t1_stall_c3", int'(st0), 1);
      next(); at_neg(); chk("t1_stall_c4", int'(st0), 0);
      chk("t1_cnt", int'(cnt0), 3);
      drain();

      // ALU RAW with forwarding: EX then WB forwarding distances.
      next(); set_instr(OP_RTYPE, 1, 2, 9);
      next(); set_instr(OP_RTYPE, 9, 0, 3);
      at_neg(); chk("t2_nostall_a", int'(st1), 0);
      next(); idle();
      at_neg(); chk("t2_fwd_ex", int'(frs1), 1);
      next(); set_instr(OP_RTYPE, 9, 0, 4);
      at_neg(); chk("t2_nostall_b", int'(st1), 0);
      next(); idle();
      at_neg(); chk("t2_fwd_wb", int'(frs1), 3);
      drain();

      // Load-use: one stall then forward from MEM.
      next(); set_instr(OP_LW, 1, 10, 0);
      next(); set_instr(OP_RTYPE, 1, 10, 4);
      at_neg(); chk("t3_stall", int'(st1), 1);
      next(); at_neg(); chk("t3_release", int'(st1), 0);
      next(); idle();
      at_neg(); chk("t3_fwd_rt", int'(frt1), 2);
      chk("t3_fwd_rs", int'(frs1), 0);
      drain();

      // r0 is never a hazard; jumps read nothing.
      next(); set_instr(OP_ADDI, 0, 0, 0);
      next(); set_instr(OP_RTYPE, 0, 0, 6);
      at_neg(); chk("t4_r0_u0", int'(st0), 0);
      chk("t4_r0_u1", int'(st1), 0);
      next(); set_instr(OP_ADDI, 0, 5, 0);
      at_neg(); chk("t4_fwd_rs", int'(frs1), 0);
      chk("t4_fwd_rt", int'(frt1), 0);
      next(); set_instr(OP_J, 5, 5, 0);
      at_neg(); chk("t4_jump", int'(st0), 0);
      drain();

      // Flush during a load-use stall kills the load.
      next(); set_instr(OP_LW, 1, 11, 0);
      next(); set_instr(OP_RTYPE, 11, 0, 7);
      #1 chk("t5_stall", int'(st1), 1);
      ex_flush = 1;
      #1 chk("t5_flush_stall", int'(st1), 0);
      next(); ex_flush = 0;
      at_neg(); chk("t5_busy", int'(bz1), 0);
      chk("t5_reissue", int'(st1), 0);
      next(); idle();
      at_neg(); chk("t5_fwd", int'(frs1), 0);
      drain();

      // Saturate the 4-bit counter, then reset.
      for (int it = 0; it < 7; it++) begin
         next(); set_instr(OP_ADDI, 0, 7, 0);
         next(); set_instr(OP_RTYPE, 7, 0, 12);
         repeat (3) next();
      end
      next(); idle();
      at_neg(); chk("t6_sat", int'(cnt2), 15);
      next(); rst = 1;
      next(); rst = 0;
      at_neg();
      chk("t6_rst_cnt2", int'(cnt2), 0);
      chk("t6_rst_cnt0", int'(cnt0), 0);
      chk("t6_rst_busy", int'(bz0 | bz1 | bz2), 0);
      chk("t6_rst_stall", int'(st0 | st1 | st2), 0);
      chk("t6_rst_fwd", int'(frs1) + int'(frt1), 0);

      // Random stream over a small register set to provoke frequent hazards.
      for (int n = 0; n < 3000; n++) begin
         int sel;
         next();
         sel = int'($urandom_range(0, 3));
         case (sel)
            0: set_instr(OP_RTYPE, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            1: set_instr(OP_ADDI, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
            2: set_instr(OP_LW, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
            default: set_instr(OP_J, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 0);
         endcase
         id_valid = ($urandom_range(0, 9) != 0);
         ex_flush = ($urandom_range(0, 9) == 0);
         rst      = ($urandom_range(0, 199) == 0);
      end
      next(); idle(); rst = 0;
      at_neg();
      next();

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
